// File: rtl/jtag_seq_master.sv
// Command-driven JTAG master: sequences TAP reset, IR/DR shifts and idle clocks
// from a valid/ready command port, always starting and ending in Run-Test/Idle.
module jtag_seq_master #(
  parameter int DIV    = 2,
  parameter int MAXLEN = 32,
  parameter int LENW   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [MAXLEN-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [MAXLEN-1:0] rsp_data,
  output logic              busy,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic              TRST
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAXLEN);
  localparam logic [1:0] OP_RESET = 2'b00, OP_IR = 2'b01, OP_DR = 2'b10, OP_IDLE = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg;
  logic [LENW-1:0]   len_reg, len_in, pre_len, slot_reg, slot_next, slot_inc;
  logic [MAXLEN-1:0] data_reg, cap_reg, mask_reg;
  logic [DW-1:0]     div_reg;
  logic              tck_reg, tms_reg, tdi_reg, trst_reg, rsp_valid_reg;
  logic              tms_next, tdi_next, shift_adv;
  logic              accept, is_shift, active, phase_end, slot_end;

  // Header TMS pattern walking from RTI to the Shift state (or TLR for op 00).
  function automatic logic pre_tms(input logic [1:0] op, input logic [LENW-1:0] s);
    case (op)
      OP_RESET: return s < LENW'(5);
      OP_IR:    return s < LENW'(2);
      OP_DR:    return s == '0;
      default:  return 1'b0;
    endcase
  endfunction

  assign cmd_ready = (state_reg == S_IDLE) && trst_reg;
  assign busy      = (state_reg != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign is_shift  = (op_reg == OP_IR) || (op_reg == OP_DR);
  assign slot_inc  = slot_reg + 1'b1;
  assign active    = (state_reg == S_PRE && pre_len != '0) ||
                     (state_reg == S_SHIFT) || (state_reg == S_POST);
  assign phase_end = (div_reg == DIV_LAST);
  assign slot_end  = active && phase_end && tck_reg;

  // Shift lengths are forced into 1..MAXLEN; idle counts pass through untouched.
  always_comb begin
    len_in = cmd_len;
    if (cmd_op != OP_IDLE) begin
      if (cmd_len == '0)          len_in = LENW'(1);
      else if (cmd_len > LEN_MAX) len_in = LEN_MAX;
    end
  end

  always_comb begin
    case (op_reg)
      OP_RESET: pre_len = LENW'(6);
      OP_IR:    pre_len = LENW'(4);
      OP_DR:    pre_len = LENW'(3);
      default:  pre_len = len_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    tms_next   = tms_reg;
    tdi_next   = tdi_reg;
    shift_adv  = 1'b0;
    case (state_reg)
      S_IDLE: if (accept) begin
        state_next = S_PRE;
        slot_next  = '0;
        tms_next   = (cmd_op != OP_IDLE);
        tdi_next   = 1'b0;
      end
      S_PRE: begin
        if (pre_len == '0) begin
          state_next = S_DONE;
        end else if (slot_end) begin
          if (slot_reg == pre_len - 1'b1) begin
            if (is_shift) begin
              state_next = S_SHIFT;
              slot_next  = '0;
              tms_next   = (len_reg == LENW'(1));
              tdi_next   = data_reg[0];
            end else begin
              state_next = S_DONE;
            end
          end else begin
            slot_next = slot_inc;
            tms_next  = pre_tms(op_reg, slot_inc);
          end
        end
      end
      S_SHIFT: if (slot_end) begin
        shift_adv = 1'b1;
        if (slot_reg == len_reg - 1'b1) begin
          state_next = S_POST;
          slot_next  = '0;
          tms_next   = 1'b1;
          tdi_next   = 1'b0;
        end else begin
          slot_next = slot_inc;
          tms_next  = (slot_inc == len_reg - 1'b1);
          tdi_next  = data_reg[1];
        end
      end
      S_POST: if (slot_end) begin
        if (slot_reg != '0) begin
          state_next = S_DONE;
        end else begin
          slot_next = slot_inc;
          tms_next  = 1'b0;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      op_reg        <= OP_RESET;
      len_reg       <= '0;
      data_reg      <= '0;
      cap_reg       <= '0;
      mask_reg      <= '0;
      slot_reg      <= '0;
      div_reg       <= '0;
      tck_reg       <= 1'b0;
      tms_reg       <= 1'b1;
      tdi_reg       <= 1'b0;
      trst_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data      <= '0;
    end else begin
      state_reg     <= state_next;
      slot_reg      <= slot_next;
      tms_reg       <= tms_next;
      tdi_reg       <= tdi_next;
      trst_reg      <= 1'b1;
      rsp_valid_reg <= (state_next == S_DONE);
      if (accept) begin
        op_reg   <= cmd_op;
        len_reg  <= len_in;
        data_reg <= cmd_data;
        cap_reg  <= '0;
        mask_reg <= MAXLEN'(1);
      end
      if (!active) begin
        div_reg <= '0;
        tck_reg <= 1'b0;
      end else if (phase_end) begin
        div_reg <= '0;
        tck_reg <= ~tck_reg;
        // TDO is taken on the low-to-high TCK transition of each shift slot.
        if (!tck_reg && state_reg == S_SHIFT && TDO)
          cap_reg <= cap_reg | mask_reg;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
      if (shift_adv) begin
        data_reg <= data_reg >> 1;
        mask_reg <= mask_reg << 1;
      end
      if (state_next == S_DONE && state_reg != S_DONE)
        rsp_data <= cap_reg;
    end
  end

  assign TCK       = tck_reg;
  assign TMS       = tms_reg;
  assign TDI       = tdi_reg;
  assign TRST      = trst_reg;
  assign rsp_valid = rsp_valid_reg;
endmodule

// File: tb/tb_jtag_seq_master.sv
// Directed bench for jtag_seq_master: drives it into a small behavioural TAP
// (IR + 1-bit bypass DR) and checks pin sequences, captured data and handshakes.
module tb_jtag_seq_master;
  localparam int LENW = 6;

  logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, TDO = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [LENW-1:0] cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, rsp_valid, busy, TCK, TMS, TDI, TRST;
  logic [31:0] rsp_data;

  jtag_seq_master #(.DIV(2), .MAXLEN(32), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TRST(TRST)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Handshake monitor, sampled on the falling clock edge.
  int acc_n = 0, rsp_cnt = 0, viol = 0;
  int acc_hist [0:63];
  int rsp_hist [0:63];
  logic [31:0] last_rsp = '0;
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      if (acc_n < 64) acc_hist[acc_n] = cyc;
      acc_n++;
    end
    if (rsp_valid) begin
      if (rsp_cnt < 64) rsp_hist[rsp_cnt] = cyc;
      rsp_cnt++;
      last_rsp = rsp_data;
    end
    if (cmd_ready && busy) viol++;
  end

  int   rises = 0;
  logic tms_log [0:4095];
  logic tdi_log [0:4095];
  always @(posedge TCK) begin
    if (rises < 4096) begin
      tms_log[rises] = TMS;
      tdi_log[rises] = TDI;
    end
    rises++;
  end

  // Behavioural 1149.1 TAP target.
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6,
                 EX2DR = 7, UPDDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                 PAIR = 13, EX2IR = 14, UPDIR = 15;
  int tap = TLR;
  logic [3:0] ir = 4'hF, ir_sh = 4'h0;
  logic byp = 1'b0;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDDR : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDDR : SHDR;
      UPDDR: return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPDIR : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPDIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      tap <= TLR;
      ir  <= 4'hF;
    end else begin
      case (tap)
        TLR:     ir    <= 4'hF;
        CAPIR:   ir_sh <= 4'b0001;
        SHIR:    ir_sh <= {TDI, ir_sh[3:1]};
        UPDIR:   ir    <= ir_sh;
        CAPDR:   byp   <= 1'b0;
        SHDR:    byp   <= TDI;
        default: ;
      endcase
      tap <= tap_next(tap, TMS);
    end
  end

  always @(negedge TCK)
    TDO <= (tap == SHIR) ? ir_sh[0] : (tap == SHDR) ? byp : 1'b0;

  // Issues one command and waits for its response; returns pin logs and latency.
  task automatic run_cmd(input logic [1:0] op, input logic [LENW-1:0] len,
                         input logic [31:0] data, output logic [31:0] rdata,
                         output int nrise, output logic [63:0] tms_v,
                         output logic [63:0] tdi_v, output int lat);
    int r0, c0, a0;
    bit got;
    r0 = rises; c0 = rsp_cnt; a0 = acc_n; got = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    for (int k = 0; k < 3000 && rsp_cnt == c0; k++) @(posedge clk);
    if (rsp_cnt == c0) chk("rsp_timeout", 64'd0, 64'd1);
    rdata = last_rsp;
    nrise = rises - r0;
    tms_v = '0; tdi_v = '0;
    for (int k = 0; k < nrise && k < 64; k++) begin
      tms_v[k] = tms_log[r0 + k];
      tdi_v[k] = tdi_log[r0 + k];
    end
    lat = (rsp_cnt > c0 && acc_n > a0) ? rsp_hist[c0] - acc_hist[a0] : -1;
  endtask

  logic [31:0] rd;
  logic [63:0] tv, dv;
  int nr, lat, c0, a0, r0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tck", TCK, 1'b0);        chk("rst_tms", TMS, 1'b1);
    chk("rst_tdi", TDI, 1'b0);        chk("rst_trst", TRST, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0); chk("rst_rspv", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);      chk("rst_rspd", rsp_data, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_trst", TRST, 1'b1);
    chk("rel_ready", cmd_ready, 1'b1);

    // 1: TAP reset.
    c0 = rsp_cnt;
    run_cmd(2'b00, 6'd0, 32'h0, rd, nr, tv, dv, lat);
    repeat (5) @(posedge clk);
    chk("t1_rises", nr, 6);  chk("t1_tms", tv, 64'h1F);
    chk("t1_rsp", rd, 32'h0); chk("t1_rspcnt", rsp_cnt - c0, 1);
    chk("t1_tap", tap, RTI);

    // 2: shift IR 4'hA.
    run_cmd(2'b01, 6'd4, 32'hA, rd, nr, tv, dv, lat);
    chk("t2_rises", nr, 10); chk("t2_tms", tv, 64'h183);
    chk("t2_tdi", dv, 64'hA0); chk("t2_ir", ir, 4'hA);
    chk("t2_rsp", rd, 32'h1);  chk("t2_tap", tap, RTI);

    // 3: shift DR 8'h5A through bypass.
    run_cmd(2'b10, 6'd8, 32'h5A, rd, nr, tv, dv, lat);
    chk("t3_rises", nr, 13); chk("t3_tms", tv, 64'hC01);
    chk("t3_rsp", rd, 32'hB4); chk("t3_tap", tap, RTI);

    // 4: back-to-back idle commands with cmd_valid held.
    c0 = rsp_cnt; a0 = acc_n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 6'd3; cmd_data = 32'h0;
    for (int k = 0; k < 500 && acc_n < a0 + 2; k++) @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 500 && rsp_cnt < c0 + 2; k++) @(posedge clk);
    chk("t4_accepts", acc_n - a0, 2);
    chk("t4_rsps", rsp_cnt - c0, 2);
    chk("t4_b2b", acc_hist[a0 + 1] - rsp_hist[c0], 1);

    // 5: idle len 0, idle len 5, DR len 0 and over-length DR.
    run_cmd(2'b11, 6'd0, 32'h0, rd, nr, tv, dv, lat);
    chk("t5_idle0_rises", nr, 0); chk("t5_idle0_lat", lat, 2);
    run_cmd(2'b11, 6'd5, 32'hFFFF_FFFF, rd, nr, tv, dv, lat);
    chk("t5_idle5_rises", nr, 5); chk("t5_idle5_tms", tv, 64'h0);
    chk("t5_idle5_rsp", rd, 32'h0);
    run_cmd(2'b10, 6'd0, 32'h1, rd, nr, tv, dv, lat);
    chk("t5_dr0_rises", nr, 6); chk("t5_dr0_tms", tv, 64'h19);
    chk("t5_dr0_tdi", dv, 64'h8);
    run_cmd(2'b10, 6'd40, 32'h8000_0001, rd, nr, tv, dv, lat);
    chk("t5_dr40_rises", nr, 37); chk("t5_dr40_rsp", rd, 32'h2);
    chk("t5_tap", tap, RTI);

    // 6: reset in the middle of a DR shift, then recover.
    c0 = rsp_cnt; r0 = rises;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd8; cmd_data = 32'hFF;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int k = 0; k < 500 && rises - r0 < 6; k++) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_tck", TCK, 1'b0);  chk("t6_tms", TMS, 1'b1);
    chk("t6_trst", TRST, 1'b0); chk("t6_busy", busy, 1'b0);
    chk("t6_tap", tap, TLR);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("t6_norsp", rsp_cnt - c0, 0);
    run_cmd(2'b00, 6'd0, 32'h0, rd, nr, tv, dv, lat);
    chk("t6_rst_rises", nr, 6);
    run_cmd(2'b01, 6'd4, 32'hA, rd, nr, tv, dv, lat);
    chk("t6_ir_rises", nr, 10); chk("t6_ir_tms", tv, 64'h183);
    chk("t6_ir", ir, 4'hA);

    chk("ready_while_busy", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
